// File: rtl/memoria_dados.sv
// memoria_dados: DEPTH x 32-bit data memory for a single-cycle datapath.
// Writes are synchronous to the rising edge of clock.
// Reads are combinational, with zero-cycle latency and no write-through bypass.
// reset is synchronous and active-low, and it clears every word.
// Optional macro BYTE_ADDR_EN makes endereco a byte address:
// the word index is then endereco[ADDR_BITS+1:2], and addresses not aligned to a word are out of range.
// When the macro is undefined, endereco is a word index.

module memoria_dados #(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] endereco,
   input  logic [31:0] dadoEscrita,
   output logic [31:0] dadoLido
);

   logic [31:0]          mem_q [DEPTH];
   logic [ADDR_BITS-1:0] idx_s;
   logic                 in_range_s;
   logic                 wr_en_s;

   // Decode the word index and decide whether the address falls inside the array
   always_comb begin
      idx_s      = {ADDR_BITS{1'b0}};
      in_range_s = 1'b0;
`ifdef BYTE_ADDR_EN
      idx_s      = endereco[ADDR_BITS+1:2];
      in_range_s = (endereco[1:0] == 2'b00) &&
                   ((endereco >> (ADDR_BITS + 2)) == 32'd0);
`else
      idx_s      = endereco[ADDR_BITS-1:0];
      in_range_s = ((endereco >> ADDR_BITS) == 32'd0);
`endif
   end

   // A write is qualified by the address check, so stray addresses never alias into the array
   always_comb begin
      if (memWrite && in_range_s) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Storage: reset clears every word and wins over a simultaneous write
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (wr_en_s) begin
         mem_q[idx_s] <= dadoEscrita;
      end else begin
         mem_q[idx_s] <= mem_q[idx_s];
      end
   end

   // Combinational read: the stored word when enabled and in range, otherwise zero
   always_comb begin
      dadoLido = 32'h0000_0000;
      if (memRead && in_range_s) begin
         dadoLido = mem_q[idx_s];
      end else begin
         dadoLido = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_memoria_dados.sv
// Scoreboard bench for memoria_dados.
// An independent array model predicts dadoLido whenever stimulus is applied.
// Each prediction goes into a queue and is compared later against the DUT output.
// Inputs are driven just after the falling edge, and the output is sampled 1 time unit later.

module tb_memoria_dados;

   localparam int DEPTH = 256;
   localparam int AB    = $clog2(DEPTH);

   logic        clock = 1'b0;
   logic        reset;
   logic        memRead;
   logic        memWrite;
   logic [31:0] endereco;
   logic [31:0] dadoEscrita;
   logic [31:0] dadoLido;

   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   memoria_dados #(.DEPTH(DEPTH)) dut (
      .clock       (clock),
      .reset       (reset),
      .memRead     (memRead),
      .memWrite    (memWrite),
      .endereco    (endereco),
      .dadoEscrita (dadoEscrita),
      .dadoLido    (dadoLido)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range_m(input logic [31:0] a);
`ifdef BYTE_ADDR_EN
      return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
`else
      return a < 32'(DEPTH);
`endif
   endfunction

   function automatic int idx_m(input logic [31:0] a);
`ifdef BYTE_ADDR_EN
      return int'(a[AB+1:2]);
`else
      return int'(a[AB-1:0]);
`endif
   endfunction

   function automatic logic [31:0] word_addr(input int i);
`ifdef BYTE_ADDR_EN
      return 32'(i * 4);
`else
      return 32'(i);
`endif
   endfunction

   task automatic drive(input logic rst, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      reset       = rst;
      memRead     = rd;
      memWrite    = wr;
      endereco    = a;
      dadoEscrita = d;
   endtask

   // predict the current output, push it, then sample and pop
   task automatic expect_now(input string tag);
      logic [31:0] e;
      e = (memRead && in_range_m(endereco)) ? model[idx_m(endereco)] : 32'h0;
      exp_q.push_back(e);
      #1;
      if (exp_q.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
         check_eq(tag, dadoLido, exp_q.pop_front());
      end
   endtask

   // one rising edge with model update, back at the next falling edge
   task automatic tick();
      @(posedge clock);
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      end else if (memWrite && in_range_m(endereco)) begin
         model[idx_m(endereco)] = dadoEscrita;
      end
      @(negedge clock);
   endtask

   task automatic write(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, 1'b1, a, d);
      tick();
   endtask

   task automatic read(input logic [31:0] a, input string tag);
      drive(1'b1, 1'b1, 1'b0, a, 32'h0);
      expect_now(tag);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clock);
      // two reset edges
      tick();
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      expect_now("idle_zero");
      for (int i = 0; i < DEPTH; i++) read(word_addr(i), "reset_sweep");

      // write then immediate read
      write(word_addr(0), 32'h0000_0001);
      read(word_addr(0), "wr_then_rd");
      check_eq("wr_then_rd_const", dadoLido, 32'h0000_0001);

      // read disabled returns zero even with data stored
      drive(1'b1, 1'b0, 1'b0, word_addr(0), 32'h0);
      expect_now("rd_disabled");

      // same-cycle read/write, no bypass
      write(word_addr(5), 32'hAAAA_5555);
      drive(1'b1, 1'b1, 1'b1, word_addr(5), 32'h1234_5678);
      expect_now("rw_before");
      check_eq("rw_before_const", dadoLido, 32'hAAAA_5555);
      tick();
      expect_now("rw_after");
      check_eq("rw_after_const", dadoLido, 32'h1234_5678);

      // out-of-range write ignored
      write(word_addr(DEPTH), 32'hDEAD_BEEF);
      read(word_addr(DEPTH), "oor_rd");
      read(32'h8000_0000, "oor_high_rd");
      read(word_addr(0), "oor_w0_unchanged");
      check_eq("oor_w0_const", dadoLido, 32'h0000_0001);

`ifdef BYTE_ADDR_EN
      write(32'd8, 32'hCAFE_F00D);
      read(32'd8, "byte_rd8");
      check_eq("byte_rd8_const", dadoLido, 32'hCAFE_F00D);
      read(32'd9, "byte_rd9");
      write(32'd10, 32'h1111_2222);
      read(32'd8, "byte_wr10_ignored");
`else
      // low address bits are ordinary index bits
      write(32'd9, 32'h0909_0909);
      read(32'd9, "word_rd9");
      check_eq("word_rd9_const", dadoLido, 32'h0909_0909);
      read(32'd8, "word_rd8");
`endif

      // reset priority over a simultaneous write
      write(word_addr(7), 32'h7777_7777);
      drive(1'b0, 1'b1, 1'b1, word_addr(3), 32'hFFFF_FFFF);
      tick();
      read(word_addr(3), "rst_prio");
      check_eq("rst_prio_const", dadoLido, 32'h0);
      read(word_addr(7), "rst_clears_w7");
      read(word_addr(5), "rst_clears_w5");

      // write in the first edge after reset deassertion is performed
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b1, word_addr(2), 32'h2222_0002);
      tick();
      read(word_addr(2), "deassert_write");
      check_eq("deassert_write_const", dadoLido, 32'h2222_0002);

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0: a = 32'($urandom_range(0, 4 * DEPTH - 1));
            1: a = $urandom();
            2: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            default: a = word_addr($urandom_range(0, DEPTH - 1));
         endcase
         drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom());
         expect_now("rand_pre");
         tick();
         expect_now("rand_post");
      end

      // no stray word changed
      for (int i = 0; i < DEPTH; i++) read(word_addr(i), "final_sweep");

      if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memoria_dados.md
MEMORIA_DADOS -- requirements
Module: memoria_dados

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words stored; SHALL be a power of two from 4 to 4096.
REQ-002 Parameter ADDR_BITS, default $clog2(DEPTH), width of the word index derived from endereco.
REQ-003 clock  input  1  sole clock; all state changes SHALL occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-005 memRead  input  1  read enable.
REQ-006 memWrite  input  1  write enable.
REQ-007 endereco  input  32  address.
REQ-008 dadoEscrita  input  32  write data.
REQ-009 dadoLido  output  32  read data.

Function
REQ-010 Storage SHALL be DEPTH words of 32 bits each.
REQ-011 Word index SHALL be endereco[ADDR_BITS-1:0] (word addressing) unless BYTE_ADDR_EN is defined (see Configuration).
REQ-012 Address in range: all endereco bits above the index field (and, with BYTE_ADDR_EN, below it) SHALL be zero.
REQ-013 Write: on a rising edge with reset=1, memWrite=1 and the address in range, the memory SHALL store dadoEscrita at the indexed word; no other word SHALL change.
REQ-014 A write to an out-of-range address SHALL be ignored.
REQ-015 Read: dadoLido SHALL be combinational, with zero-cycle latency. It SHALL equal the stored word at the index when memRead=1 and the address is in range, and SHALL be 32'h0 otherwise.
REQ-016 Read and write in the same cycle to the same address: before the edge, dadoLido SHALL show the old word; after the edge, it SHALL show the newly written word. There SHALL be no write-through bypass.
REQ-017 memRead and memWrite both 0: memory SHALL be unchanged and dadoLido SHALL be 0.
REQ-018 dadoLido SHALL never be X once reset has been applied.

Reset
REQ-019 On a rising edge with reset=0, every word SHALL be cleared to 32'h0.
REQ-020 Reset SHALL take priority over a simultaneous write; that write SHALL be lost.
REQ-021 Reset asserted mid-operation SHALL clear all previously written data at that edge. dadoLido SHALL therefore read 0 after that edge whenever memRead=1.
REQ-022 Deasserting reset SHALL take effect at the next rising edge; a write presented at that edge SHALL be performed.

Configuration
REQ-023 Macro BYTE_ADDR_EN, when defined: endereco SHALL be a byte address and the word index SHALL be endereco[ADDR_BITS+1:2].
REQ-024 With BYTE_ADDR_EN defined, an address with endereco[1:0] != 0 SHALL be out of range: writes ignored, reads return 0.
REQ-025 When BYTE_ADDR_EN is not defined: the index SHALL be endereco[ADDR_BITS-1:0], and endereco[1:0] SHALL have no special meaning.

Verification
REQ-026 Reset with reset=0 for 2 edges, then reset=1; memRead=1 at endereco=0..DEPTH-1 -> dadoLido=0 for every address.
REQ-027 Write then read: memWrite=1, endereco=0, dadoEscrita=1 for one edge; then memWrite=0, memRead=1, endereco=0 -> dadoLido=32'h00000001 immediately, no extra cycle.
REQ-028 Same-cycle read/write: word 5 holds 32'hAAAA5555; present memRead=1, memWrite=1, endereco=5, dadoEscrita=32'h12345678 -> dadoLido=32'hAAAA5555 before the edge and 32'h12345678 after it.
REQ-029 Out-of-range: write 32'hDEADBEEF to endereco=DEPTH, then read endereco=DEPTH -> dadoLido=0; read endereco=0 -> word 0 unchanged.
REQ-030 Reset priority: reset=0 and memWrite=1, endereco=3, dadoEscrita=32'hFFFFFFFF on the same edge -> reading endereco=3 afterwards returns 0.
REQ-031 BYTE_ADDR_EN build: write 32'hCAFEF00D at endereco=8 -> reading endereco=8 returns 32'hCAFEF00D; reading endereco=9 returns 0; writing at endereco=10 leaves memory unchanged.
